// File: rtl/ps2_key_event_pkg.sv
// Shared constants, decoder state encoding and helper functions for the
// PS/2 keyboard front end.
package ps2_key_event_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] ASC_ENTER = 8'h0D;
  localparam logic [7:0] ASC_NONE  = 8'h00;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_BRK     = 2'd1,
    DEC_EXT     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  // True when the nine bits (8 data + parity) carry odd parity.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    odd_parity_ok = ^bits;
  endfunction

  // Scan code set 2 to ASCII; shift only affects letters.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc, input logic shift);
    logic [7:0] asc;
    logic       letter;
    letter = 1'b1;
    case (sc)
      8'h1C: asc = 8'h61;  8'h32: asc = 8'h62;  8'h21: asc = 8'h63;  8'h23: asc = 8'h64;
      8'h24: asc = 8'h65;  8'h2B: asc = 8'h66;  8'h34: asc = 8'h67;  8'h33: asc = 8'h68;
      8'h43: asc = 8'h69;  8'h3B: asc = 8'h6A;  8'h42: asc = 8'h6B;  8'h4B: asc = 8'h6C;
      8'h3A: asc = 8'h6D;  8'h31: asc = 8'h6E;  8'h44: asc = 8'h6F;  8'h4D: asc = 8'h70;
      8'h15: asc = 8'h71;  8'h2D: asc = 8'h72;  8'h1B: asc = 8'h73;  8'h2C: asc = 8'h74;
      8'h3C: asc = 8'h75;  8'h2A: asc = 8'h76;  8'h1D: asc = 8'h77;  8'h22: asc = 8'h78;
      8'h35: asc = 8'h79;  8'h1A: asc = 8'h7A;
      default: begin
        letter = 1'b0;
        case (sc)
          8'h45: asc = 8'h30;  8'h16: asc = 8'h31;  8'h1E: asc = 8'h32;  8'h26: asc = 8'h33;
          8'h25: asc = 8'h34;  8'h2E: asc = 8'h35;  8'h36: asc = 8'h36;  8'h3D: asc = 8'h37;
          8'h3E: asc = 8'h38;  8'h46: asc = 8'h39;
          8'h5A: asc = ASC_ENTER;
          8'h29: asc = 8'h20;
          default: asc = ASC_NONE;
        endcase
      end
    endcase
    if (letter && shift) begin
      scan_to_ascii = asc - 8'h20;
    end else begin
      scan_to_ascii = asc;
    end
  endfunction

endpackage

// File: rtl/ps2_key_event_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge sampling, frame checks
// and an inactivity timeout that abandons partial frames.
import ps2_key_event_pkg::*;

module ps2_rx #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       err_stb
);

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_CYC);

  logic [2:0]    clk_sync_r;   // [0] meta, [1] synced, [2] previous synced
  logic [1:0]    dat_sync_r;
  logic [3:0]    bit_cnt_r;
  logic [9:0]    frame_r;      // start, d0..d7, parity
  logic [TW-1:0] idle_cnt_r;
  logic          fall_s;
  logic          frame_ok_s;

  assign fall_s     = clk_sync_r[2] & ~clk_sync_r[1];
  assign frame_ok_s = (frame_r[0] == 1'b0) && odd_parity_ok(frame_r[9:1]) && (dat_sync_r[1] == 1'b1);

  // Two-flop synchronisers, idle-high after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_r <= 3'b111;
      dat_sync_r <= 2'b11;
    end else begin
      clk_sync_r <= {clk_sync_r[1:0], ps2_clk};
      dat_sync_r <= {dat_sync_r[0], ps2_data};
    end
  end

  // Frame assembly, stop-bit check and partial-frame timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r  <= 4'd0;
      frame_r    <= 10'd0;
      idle_cnt_r <= '0;
      byte_stb   <= 1'b0;
      byte_data  <= 8'h00;
      err_stb    <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
      if (fall_s) begin
        idle_cnt_r <= '0;
        if (bit_cnt_r == 4'd10) begin
          bit_cnt_r <= 4'd0;
          if (frame_ok_s) begin
            byte_stb  <= 1'b1;
            byte_data <= frame_r[8:1];
          end else begin
            err_stb <= 1'b1;
          end
        end else begin
          frame_r[bit_cnt_r] <= dat_sync_r[1];
          bit_cnt_r          <= bit_cnt_r + 4'd1;
        end
      end else if (bit_cnt_r != 4'd0) begin
        if (idle_cnt_r >= TIMEOUT_V) begin
          bit_cnt_r  <= 4'd0;
          idle_cnt_r <= '0;
        end else begin
          idle_cnt_r <= idle_cnt_r + TW'(1);
        end
      end else begin
        idle_cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// Keyboard front end: decodes make/break/extended scan codes into one ASCII
// event per key press and queues them for the game logic.
import ps2_key_event_pkg::*;

module ps2_key_event #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  output logic [7:0] ev_data,
  input  logic       ev_ready,
  output logic [7:0] key_ascii,
  output logic       shift_held,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic       rx_stb_s;
  logic       rx_err_s;
  logic [7:0] rx_byte_s;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_stb  (rx_stb_s),
    .byte_data (rx_byte_s),
    .err_stb   (rx_err_s)
  );

  // Saturating frame error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'h00;
    end else if (rx_err_s && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end else begin
      err_count <= err_count;
    end
  end

  dec_state_t state_r, state_next_s;
  logic [7:0] make_ascii_s;
  logic       brk_match_s;
  logic       is_shift_s;
  logic [7:0] key_next_s;
  logic       shift_next_s;
  logic       push_s;
  logic [7:0] push_data_s;
  logic       push_r;
  logic [7:0] push_data_r;

  assign make_ascii_s = scan_to_ascii(rx_byte_s, shift_held);
  assign is_shift_s   = (rx_byte_s == SC_LSHIFT) || (rx_byte_s == SC_RSHIFT);
  // Release matches either case so a shift released first cannot strand the key
  assign brk_match_s  = (key_ascii != ASC_NONE) &&
                        ((scan_to_ascii(rx_byte_s, 1'b0) == key_ascii) ||
                         (scan_to_ascii(rx_byte_s, 1'b1) == key_ascii));

  // Decoder state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= DEC_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Decoder next-state logic, advanced once per received byte
  always_comb begin
    state_next_s = state_r;
    if (rx_stb_s) begin
      case (state_r)
        DEC_IDLE: begin
          if (rx_byte_s == SC_BREAK) begin
            state_next_s = DEC_BRK;
          end else if (rx_byte_s == SC_EXT) begin
            state_next_s = DEC_EXT;
          end else begin
            state_next_s = DEC_IDLE;
          end
        end
        DEC_EXT: begin
          if (rx_byte_s == SC_BREAK) begin
            state_next_s = DEC_EXT_BRK;
          end else begin
            state_next_s = DEC_IDLE;
          end
        end
        DEC_BRK:     state_next_s = DEC_IDLE;
        DEC_EXT_BRK: state_next_s = DEC_IDLE;
        default:     state_next_s = DEC_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Decoder outputs: held key, shift level and event push request
  always_comb begin
    key_next_s   = key_ascii;
    shift_next_s = shift_held;
    push_s       = 1'b0;
    push_data_s  = ASC_NONE;
    if (rx_stb_s) begin
      case (state_r)
        DEC_IDLE: begin
          if (is_shift_s) begin
            shift_next_s = 1'b1;
          end else if ((make_ascii_s != ASC_NONE) && (make_ascii_s != key_ascii)) begin
            push_s      = 1'b1;
            push_data_s = make_ascii_s;
            key_next_s  = make_ascii_s;
          end else begin
            key_next_s = key_ascii;
          end
        end
        DEC_BRK: begin
          if (is_shift_s) begin
            shift_next_s = 1'b0;
          end else if (brk_match_s) begin
            key_next_s = ASC_NONE;
          end else begin
            key_next_s = key_ascii;
          end
        end
        DEC_EXT: begin
          if ((rx_byte_s == SC_ENTER) && (key_ascii != ASC_ENTER)) begin
            push_s      = 1'b1;
            push_data_s = ASC_ENTER;
            key_next_s  = ASC_ENTER;
          end else begin
            key_next_s = key_ascii;
          end
        end
        DEC_EXT_BRK: begin
          if ((rx_byte_s == SC_ENTER) && (key_ascii == ASC_ENTER)) begin
            key_next_s = ASC_NONE;
          end else begin
            key_next_s = key_ascii;
          end
        end
        default: key_next_s = key_ascii;
      endcase
    end else begin
      key_next_s = key_ascii;
    end
  end

  // Registered decoder outputs; the push stage sets the three-cycle event latency
  always_ff @(posedge clk) begin
    if (reset) begin
      key_ascii   <= ASC_NONE;
      shift_held  <= 1'b0;
      push_r      <= 1'b0;
      push_data_r <= ASC_NONE;
    end else begin
      key_ascii   <= key_next_s;
      shift_held  <= shift_next_s;
      push_r      <= push_s;
      push_data_r <= push_data_s;
    end
  end

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [AW:0]   count_r, count_next_s;
  logic [AW-1:0] head_idx_s;
  logic          full_s, pop_s, push_ok_s;

  assign full_s     = (count_r == DEPTH_V);
  assign pop_s      = ev_ready && ev_valid;
  assign push_ok_s  = push_r && (!full_s || pop_s);
  assign head_idx_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + (AW + 1)'(1);
      2'b01:   count_next_s = count_r - (AW + 1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers, registered head and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      ev_valid <= 1'b0;
      ev_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_r && full_s && !pop_s) begin
        overflow <= 1'b1;
      end
      count_r  <= count_next_s;
      ev_valid <= (count_next_s != '0);
      if (count_next_s == '0) begin
        ev_data <= 8'h00;
      end else if (push_ok_s && (wr_ptr_r == head_idx_s)) begin
        ev_data <= push_data_r;
      end else begin
        ev_data <= mem_r[head_idx_s];
      end
    end
  end

endmodule
